// File: rtl/rij_ctrl_if.sv
// Control bundle between the R/I/J CPU controller and its datapath
// (fetch unit, register file, ALU, operand muxes, data memory).
interface rij_ctrl_if;
  logic [31:0] Inst_code;
  logic        ZF;
  logic [1:0]  PC_s;
  logic        PC_Write;
  logic        IR_Write;
  logic        Write_Reg;
  logic [1:0]  rd_sel;
  logic [1:0]  wr_data_s;
  logic [2:0]  ALU_OP;
  logic        imm_s;
  logic        imm_ext;
  logic        Mem_Write;
  logic [31:0] IR;
  logic [2:0]  state;
  logic        illegal;

  modport master (
    input  Inst_code, ZF,
    output PC_s, PC_Write, IR_Write, Write_Reg, rd_sel, wr_data_s,
           ALU_OP, imm_s, imm_ext, Mem_Write, IR, state, illegal
  );

  modport slave (
    output Inst_code, ZF,
    input  PC_s, PC_Write, IR_Write, Write_Reg, rd_sel, wr_data_s,
           ALU_OP, imm_s, imm_ext, Mem_Write, IR, state, illegal
  );
endinterface

// File: rtl/rij_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB controller for the R/I/J CPU. Latches the
// instruction, decodes it and sequences exactly one PC update per instruction.
module rij_ctrl (
  input logic       clk,
  input logic       rst,
  rij_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic [5:0]  opcode, funct;

  logic       legal, is_rtype, is_nop, is_jr, is_j, is_jal;
  logic       is_beq, is_bne, is_lw, is_sw;
  logic [2:0] alu_op_dec;
  logic       imm_s_dec, imm_ext_dec;

  logic       pc_write, ir_write, write_reg, mem_write, illegal_p, alu_en;
  logic [1:0] pc_s, rd_sel, wr_data_s;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF)
        ir_q <= bus.Inst_code;
    end
  end

  always_comb begin
    legal       = 1'b1;
    is_rtype    = 1'b0;
    is_nop      = 1'b0;
    is_jr       = 1'b0;
    is_j        = 1'b0;
    is_jal      = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_lw       = 1'b0;
    is_sw       = 1'b0;
    alu_op_dec  = 3'b000;
    imm_s_dec   = 1'b0;
    imm_ext_dec = 1'b0;
    case (opcode)
      6'b000000: begin
        is_rtype = 1'b1;
        case (funct)
          6'b000000: is_nop     = 1'b1;
          6'b001000: is_jr      = 1'b1;
          6'b100000: alu_op_dec = 3'b100;
          6'b100010: alu_op_dec = 3'b101;
          6'b100100: alu_op_dec = 3'b000;
          6'b100101: alu_op_dec = 3'b001;
          6'b100110: alu_op_dec = 3'b010;
          6'b100111: alu_op_dec = 3'b011;
          6'b101010: alu_op_dec = 3'b110;
          default:   legal      = 1'b0;
        endcase
      end
      6'b000010: is_j   = 1'b1;
      6'b000011: is_jal = 1'b1;
      6'b000100: begin is_beq = 1'b1; alu_op_dec = 3'b101; end
      6'b000101: begin is_bne = 1'b1; alu_op_dec = 3'b101; end
      6'b001000: begin alu_op_dec = 3'b100; imm_s_dec = 1'b1; imm_ext_dec = 1'b1; end
      6'b001100: begin alu_op_dec = 3'b000; imm_s_dec = 1'b1; end
      6'b001101: begin alu_op_dec = 3'b001; imm_s_dec = 1'b1; end
      6'b001110: begin alu_op_dec = 3'b010; imm_s_dec = 1'b1; end
      6'b100011: begin is_lw = 1'b1; alu_op_dec = 3'b100; imm_s_dec = 1'b1; imm_ext_dec = 1'b1; end
      6'b101011: begin is_sw = 1'b1; alu_op_dec = 3'b100; imm_s_dec = 1'b1; imm_ext_dec = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  // Every terminal state raises pc_write exactly once, so the fetch unit's
  // PC_new is always instruction address + 4 while this instruction runs.
  always_comb begin
    state_d   = S_IF;
    pc_write  = 1'b0;
    pc_s      = 2'b00;
    ir_write  = 1'b0;
    write_reg = 1'b0;
    rd_sel    = 2'b00;
    wr_data_s = 2'b00;
    mem_write = 1'b0;
    illegal_p = 1'b0;
    alu_en    = 1'b0;
    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (!legal) begin
          illegal_p = 1'b1;
          pc_write  = 1'b1;
        end else if (is_j || is_jal) begin
          pc_write = 1'b1;
          pc_s     = 2'b11;
          if (is_jal) begin
            write_reg = 1'b1;
            rd_sel    = 2'b10;
            wr_data_s = 2'b10;
          end
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_s     = 2'b01;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_en = 1'b1;
        if (is_beq || is_bne) begin
          pc_write = 1'b1;
          if ((is_beq && bus.ZF) || (is_bne && !bus.ZF))
            pc_s = 2'b10;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_en = 1'b1;
        if (is_sw) begin
          mem_write = 1'b1;
          pc_write  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        alu_en    = 1'b1;
        write_reg = !is_nop;
        rd_sel    = is_rtype ? 2'b00 : 2'b01;
        wr_data_s = is_lw ? 2'b01 : 2'b00;
        pc_write  = 1'b1;
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset parks the FSM in IF, whose IR_Write must not leak out while rst is high.
  assign bus.PC_Write  = pc_write  & ~rst;
  assign bus.IR_Write  = ir_write  & ~rst;
  assign bus.Write_Reg = write_reg & ~rst;
  assign bus.Mem_Write = mem_write & ~rst;
  assign bus.illegal   = illegal_p & ~rst;
  assign bus.PC_s      = pc_s;
  assign bus.rd_sel    = rd_sel;
  assign bus.wr_data_s = wr_data_s;
  assign bus.ALU_OP    = alu_en ? alu_op_dec  : 3'b000;
  assign bus.imm_s     = alu_en ? imm_s_dec   : 1'b0;
  assign bus.imm_ext   = alu_en ? imm_ext_dec : 1'b0;
  assign bus.IR        = ir_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_rij_ctrl.sv
// Scoreboard bench for rij_ctrl: each instruction's expected per-cycle
// control pattern is queued by the stimulus and checked by a monitor.
module tb_rij_ctrl;

  logic clk;
  logic rst;

  rij_ctrl_if bus();

  rij_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum {K_R, K_NOP, K_JR, K_J, K_JAL, K_BEQ, K_BNE, K_LW, K_SW, K_IAR, K_ILL} kind_t;

  typedef struct {
    logic [2:0]  st;
    logic        irw;
    logic        pcw;
    logic [1:0]  pcs;
    logic        wr;
    logic [1:0]  rds;
    logic [1:0]  wds;
    logic        mw;
    logic        ill;
    logic [2:0]  aop;
    logic        ims;
    logic        ime;
    logic [31:0] ir;
    bit          careAlu;
    bit          careExt;
  } exp_t;

  exp_t        expq[$];
  int          compared   = 0;
  int          mismatched = 0;
  bit          checking   = 0;
  logic [31:0] prevIr     = '0;

  logic [5:0] rFuncts [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [5:0] iOps    [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0E};

  // Instruction class plus the ALU operation and extension mode it implies.
  function automatic kind_t classify(input logic [31:0] w, output logic [2:0] aop, output logic ime);
    kind_t k;
    aop = 3'd0;
    ime = 1'b0;
    k   = K_ILL;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h00: k = K_NOP;
        6'h08: k = K_JR;
        6'h20: begin k = K_R; aop = 3'd4; end
        6'h22: begin k = K_R; aop = 3'd5; end
        6'h24: begin k = K_R; aop = 3'd0; end
        6'h25: begin k = K_R; aop = 3'd1; end
        6'h26: begin k = K_R; aop = 3'd2; end
        6'h27: begin k = K_R; aop = 3'd3; end
        6'h2A: begin k = K_R; aop = 3'd6; end
        default: k = K_ILL;
      endcase
      6'h02: k = K_J;
      6'h03: k = K_JAL;
      6'h04: begin k = K_BEQ; aop = 3'd5; end
      6'h05: begin k = K_BNE; aop = 3'd5; end
      6'h08: begin k = K_IAR; aop = 3'd4; ime = 1'b1; end
      6'h0C: begin k = K_IAR; aop = 3'd0; end
      6'h0D: begin k = K_IAR; aop = 3'd1; end
      6'h0E: begin k = K_IAR; aop = 3'd2; end
      6'h23: begin k = K_LW;  aop = 3'd4; ime = 1'b1; end
      6'h2B: begin k = K_SW;  aop = 3'd4; ime = 1'b1; end
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic exp_t blank(input logic [2:0] st, input logic [31:0] ir);
    exp_t e;
    e.st = st; e.irw = 0; e.pcw = 0; e.pcs = 0; e.wr = 0; e.rds = 0; e.wds = 0;
    e.mw = 0; e.ill = 0; e.aop = 0; e.ims = 0; e.ime = 0; e.ir = ir;
    e.careAlu = 0; e.careExt = 0;
    return e;
  endfunction

  // Builds the expected cycle sequence for one instruction, drives it and
  // waits out exactly as many cycles as the sequence is long.
  task automatic applyStimulus(input logic [31:0] inst, input logic zf);
    exp_t e;
    kind_t k;
    logic [2:0] aop;
    logic ime;
    int n;
    bit usesImm;
    k = classify(inst, aop, ime);
    usesImm = (k == K_IAR) || (k == K_LW) || (k == K_SW);
    bus.Inst_code = inst;
    bus.ZF = zf;
    n = 0;
    e = blank(3'd0, prevIr); e.irw = 1; expq.push_back(e); n++;
    e = blank(3'd1, inst);
    if (k inside {K_J, K_JAL, K_JR, K_ILL}) begin
      e.pcw = 1;
      e.pcs = (k == K_JR) ? 2'b01 : (k == K_ILL) ? 2'b00 : 2'b11;
      if (k == K_JAL) begin e.wr = 1; e.rds = 2'b10; e.wds = 2'b10; end
      if (k == K_ILL) e.ill = 1;
      expq.push_back(e); n++;
    end else begin
      expq.push_back(e); n++;
      e = blank(3'd2, inst);
      e.careAlu = (k != K_NOP); e.aop = aop; e.ims = usesImm;
      e.careExt = usesImm; e.ime = ime;
      if (k == K_BEQ || k == K_BNE) begin
        e.pcw = 1;
        e.pcs = ((k == K_BEQ && zf) || (k == K_BNE && !zf)) ? 2'b10 : 2'b00;
        expq.push_back(e); n++;
      end else begin
        expq.push_back(e); n++;
        if (k == K_LW || k == K_SW) begin
          e.st = 3'd3;
          if (k == K_SW) begin e.mw = 1; e.pcw = 1; e.pcs = 2'b00; end
          expq.push_back(e); n++;
        end
        if (k != K_SW) begin
          e.st = 3'd4; e.mw = 0; e.pcw = 1; e.pcs = 2'b00;
          e.wr = (k != K_NOP);
          e.rds = (k == K_R || k == K_NOP) ? 2'b00 : 2'b01;
          e.wds = (k == K_LW) ? 2'b01 : 2'b00;
          expq.push_back(e); n++;
        end
      end
    end
    prevIr = inst;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input exp_t e);
    bit ok;
    ok = (bus.state === e.st) && (bus.IR_Write === e.irw) && (bus.PC_Write === e.pcw) &&
         (bus.Write_Reg === e.wr) && (bus.Mem_Write === e.mw) && (bus.illegal === e.ill) &&
         (bus.IR === e.ir) &&
         (!e.pcw || bus.PC_s === e.pcs) &&
         (!e.wr || (bus.rd_sel === e.rds && bus.wr_data_s === e.wds)) &&
         (!e.careAlu || (bus.ALU_OP === e.aop && bus.imm_s === e.ims)) &&
         (!e.careExt || bus.imm_ext === e.ime);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL cycle_check t=%0t got st=%0d irw=%b pcw=%b pcs=%b wr=%b rds=%b wds=%b mw=%b ill=%b aop=%b ims=%b ime=%b ir=%h | want st=%0d irw=%b pcw=%b pcs=%b wr=%b rds=%b wds=%b mw=%b ill=%b aop=%b ims=%b ime=%b ir=%h",
               $time, bus.state, bus.IR_Write, bus.PC_Write, bus.PC_s, bus.Write_Reg, bus.rd_sel,
               bus.wr_data_s, bus.Mem_Write, bus.illegal, bus.ALU_OP, bus.imm_s, bus.imm_ext, bus.IR,
               e.st, e.irw, e.pcw, e.pcs, e.wr, e.rds, e.wds, e.mw, e.ill, e.aop, e.ims, e.ime, e.ir);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // While reset is high the block must look fully idle.
  task automatic checkResetState(input string name);
    checkValue({name, "_state"}, 32'(bus.state), 32'd0);
    checkValue({name, "_ir"}, bus.IR, 32'd0);
    checkValue({name, "_strobes"},
               32'({bus.PC_Write, bus.IR_Write, bus.Write_Reg, bus.Mem_Write, bus.illegal}), 32'd0);
    checkValue({name, "_selects"},
               32'({bus.PC_s, bus.rd_sel, bus.wr_data_s, bus.ALU_OP, bus.imm_s, bus.imm_ext}), 32'd0);
  endtask

  function automatic logic [31:0] randInst();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] w;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  w = {6'h00, rs, rt, rd, 5'($urandom), rFuncts[$urandom_range(0, 6)]};
      1:  w = {6'h00, 20'($urandom), 6'h00};
      2:  w = {6'h00, rs, 15'd0, 6'h08};
      3:  w = {6'h02, 26'($urandom)};
      4:  w = {6'h03, 26'($urandom)};
      5:  w = {6'h04, rs, rt, imm};
      6:  w = {6'h05, rs, rt, imm};
      7:  w = {6'h23, rs, rt, imm};
      8:  w = {6'h2B, rs, rt, imm};
      9:  w = {iOps[$urandom_range(0, 3)], rs, rt, imm};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL queue_underflow t=%0t got empty want pending cycle", $time);
        end else begin
          checkOutput(expq.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.Inst_code = 32'h0;
    bus.ZF = 1'b0;
    @(posedge clk);
    #2;
    checkResetState("reset_idle");
    @(posedge clk);
    #2;
    rst = 1'b0;
    checking = 1;
    $display("[TB] directed instructions");
    applyStimulus(32'h00221820, 1'b0);
    applyStimulus(32'h8C050004, 1'b0);
    applyStimulus(32'hAC050004, 1'b1);
    applyStimulus(32'h10220003, 1'b1);
    applyStimulus(32'h10220003, 1'b0);
    applyStimulus(32'h14220003, 1'b1);
    applyStimulus(32'h14220003, 1'b0);
    applyStimulus(32'h0C000010, 1'b0);
    applyStimulus(32'hFC000000, 1'b0);
    applyStimulus(32'h00000000, 1'b0);
    applyStimulus(32'h03E00008, 1'b0);
    applyStimulus(32'h3021FFFF, 1'b0);
    applyStimulus(32'h2021FFFF, 1'b0);
    applyStimulus(32'h0022183F, 1'b0);
    $display("[TB] random instructions");
    for (int i = 0; i < 200; i++)
      applyStimulus(randInst(), 1'($urandom));

    // Reset in the middle of EX must abandon the instruction at once.
    checking = 0;
    bus.Inst_code = 32'h00221820;
    repeat (2) @(posedge clk);
    #2;
    checkValue("pre_reset_state_ex", 32'(bus.state), 32'd2);
    rst = 1'b1;
    #1;
    checkResetState("reset_mid_ex");
    @(posedge clk);
    #2;
    checkResetState("reset_held");
    rst = 1'b0;
    prevIr = 32'h0;
    checking = 1;
    applyStimulus(32'h0C000010, 1'b0);
    applyStimulus(32'h00221820, 1'b0);
    checking = 0;
    checkValue("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rij_ctrl.md
# rij_ctrl

Multi-cycle control FSM for the R/I/J CPU. It latches each instruction word from the fetch unit and sequences the fetch unit's PC update (`PC_s`, `PC_Write`). It also drives the register file, ALU, operand muxes and data memory through IF/ID/EX/MEM/WB states. `PC_Write` pulses exactly once per instruction, in the instruction's final state. The fetch unit's `PC_new` therefore always equals instruction address + 4 when a branch, jump or `jal` link value is consumed.

## Interface
- No parameters.
- `clk` input 1: system clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `Inst_code` input 32: instruction word from the fetch unit.
- `ZF` input 1: ALU zero flag, combinational from the current ALU operation.
- `PC_s` output 2: fetch unit next-PC select: 00 = PC+4, 01 = rs register, 10 = branch, 11 = jump.
- `PC_Write` output 1: fetch unit PC update enable.
- `IR_Write` output 1: high in IF; internal IR captures `Inst_code`.
- `Write_Reg` output 1: register file write strobe.
- `rd_sel` output 2: write address: 00 = rd, 01 = rt, 10 = $31.
- `wr_data_s` output 2: write data: 00 = ALU F, 01 = memory, 10 = PC_new.
- `ALU_OP` output 3: 000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 slt.
- `imm_s` output 1: ALU B source: 0 = rt, 1 = extended immediate.
- `imm_ext` output 1: 0 = zero-extend, 1 = sign-extend.
- `Mem_Write` output 1: data memory write strobe.
- `IR` output 32: latched instruction, feeding register addresses, immediate and `in_3`.
- `state` output 3: current state, for debug.
- `illegal` output 1: one-cycle pulse in ID on an undecodable instruction.

## Operation
- States: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4. Values 5–7 are unreachable; if entered, the FSM goes to IF.
- Outputs are Moore-decoded from state and IR, except branch resolution, which also uses `ZF`.
- IF: `IR_Write` = 1; always goes to ID.
- ID: decode `IR[31:26]` and `IR[5:0]`.
  - j (000010): `PC_Write` = 1, `PC_s` = 11, then IF.
  - jal (000011): same as j, plus `Write_Reg` = 1, `rd_sel` = 10, `wr_data_s` = 10.
  - jr (R-type, funct 001000): `PC_Write` = 1, `PC_s` = 01, then IF.
  - Illegal opcode or funct: `illegal` = 1, `PC_Write` = 1, `PC_s` = 00, then IF.
  - All other instructions go to EX.
- R-type funct decode:
  - add 100000 → 100, sub 100010 → 101, and 100100 → 000, or 100101 → 001, xor 100110 → 010, nor 100111 → 011, slt 101010 → 110.
  - funct 000000 (includes the all-zero word) is a NOP: normal 4-cycle path, `Write_Reg` suppressed.
- I-type: `imm_s` = 1.
  - addi 001000: add, sign-extend.
  - andi 001100: and, zero-extend.
  - ori 001101: or, zero-extend.
  - xori 001110: xor, zero-extend.
  - lw 100011 / sw 101011: add, sign-extend.
- beq 000100 / bne 000101: `imm_s` = 0, `ALU_OP` = 101 in EX.
- EX: `ALU_OP` and `imm_s` held as decoded.
  - beq/bne: `PC_Write` = 1.
    - `PC_s` = 10 if (beq and ZF = 1) or (bne and ZF = 0); otherwise 00.
    - Then IF.
  - lw/sw go to MEM; all others go to WB.
- MEM: lw goes to WB. sw: `Mem_Write` = 1, `PC_Write` = 1, `PC_s` = 00, then IF.
- WB: `Write_Reg` = 1 (except NOP), `PC_Write` = 1, `PC_s` = 00, then IF.
  - R-type: `rd_sel` = 00, `wr_data_s` = 00.
  - I-arith: `rd_sel` = 01, `wr_data_s` = 00.
  - lw: `rd_sel` = 01, `wr_data_s` = 01.
- `ALU_OP`, `imm_s` and `imm_ext` are held stable through EX, MEM and WB of one instruction.
- Outside the states listed above, all strobes are 0.

## Timing
- Reset (asynchronous, immediate): `state` = IF, IR = 0.
  - While `rst` = 1, `PC_Write`, `IR_Write`, `Write_Reg`, `Mem_Write` and `illegal` are forced to 0.
  - `PC_s`, `rd_sel`, `wr_data_s`, `ALU_OP`, `imm_s` and `imm_ext` read 0.
- First rising edge after `rst` falls: FSM remains in IF with `IR_Write` = 1, so IR captures at the end of that cycle.
- Reset mid-instruction abandons the instruction. No write strobe is issued for it, and the PC is not advanced by this block.
- `Inst_code` must be stable at the rising edge that ends IF.
- `PC_Write` and `PC_s` are stable for the whole final-state cycle. The fetch unit consumes them on that cycle's falling edge, so the next IF sees the new PC.
- Cycles per instruction:
  - j, jal, jr, illegal: 2.
  - beq, bne: 3.
  - R-type, I-arith, sw: 4.
  - lw: 5.
- Exactly one `PC_Write` cycle per instruction. `Write_Reg` and `Mem_Write` are each at most one cycle per instruction.

## Test plan
- Reset, then add $3,$1,$2 (0x00221820) → states IF, ID, EX, WB.
  - In WB: `Write_Reg` = 1, `rd_sel` = 00, `ALU_OP` = 100, `PC_Write` = 1, `PC_s` = 00.
- lw $5,4($0) (0x8C050004) → 5 cycles, `imm_ext` = 1, `wr_data_s` = 01 in WB.
- sw (0xAC050004) → `Mem_Write` = 1 only in MEM, then back to IF.
- beq $1,$2,3 (0x10220003):
  - ZF = 1 in EX → `PC_s` = 10.
  - ZF = 0 in EX → `PC_s` = 00.
  - bne gives the inverse.
- jal 0x40 (0x0C000010) → in ID: `PC_s` = 11, `Write_Reg` = 1, `rd_sel` = 10, `wr_data_s` = 10; next state IF.
- Illegal opcode 0xFC000000 → `illegal` pulses for 1 cycle with `PC_s` = 00 and no `Write_Reg`.
- `rst` asserted mid-EX → state = IF immediately, strobes 0.
